// File: rtl/mlp_pkg.sv
// Shared constants and loader state encoding for the int4 MLP inference engine.
package mlp_pkg;

  localparam int NUM_PIXELS  = 784;
  localparam int NUM_CLASSES = 10;
  localparam int PIX_W       = 8;
  localparam int Q_W         = 4;

  localparam logic [2:0] ST_LOAD   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  typedef enum logic [2:0] {
    LOAD   = ST_LOAD,
    DRAIN  = ST_DRAIN,
    START  = ST_START,
    WAIT   = ST_WAIT,
    RESULT = ST_RESULT
  } loader_state_t;

endpackage

// File: rtl/mnist_image_loader_if.sv
// Signal bundle between the image loader and its pixel source, input RAM, engine and result sink.
interface mnist_image_loader_if #(
  parameter int ADDR_W = 10
);
  import mlp_pkg::*;

  // Valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
  // the sender holds data stable while valid is high and ready is low.
  logic              s_valid;
  logic              s_ready;
  logic [PIX_W-1:0]  s_data;
  logic              s_last;

  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [Q_W-1:0]    ram_wdata;

  logic              mlp_start;
  logic              mlp_done;
  logic [3:0]        mlp_class;
  logic              mlp_clear;

  logic              result_valid;
  logic [3:0]        result_class;
  logic              result_ready;

  logic              frame_error;
  logic [2:0]        state_dbg;

  modport master (
    input  s_valid, s_data, s_last, mlp_done, mlp_class, result_ready,
    output s_ready, ram_wen, ram_addr, ram_wdata, mlp_start, mlp_clear,
           result_valid, result_class, frame_error, state_dbg
  );

  modport slave (
    output s_valid, s_data, s_last, mlp_done, mlp_class, result_ready,
    input  s_ready, ram_wen, ram_addr, ram_wdata, mlp_start, mlp_clear,
           result_valid, result_class, frame_error, state_dbg
  );

endinterface

// File: rtl/pixel_quantizer.sv
// Combinational 8-bit to 4-bit pixel quantizer; ROUND=1 rounds half-up and saturates, ROUND=0 truncates.
module pixel_quantizer
  import mlp_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic [PIX_W-1:0] pixel,
  output logic [Q_W-1:0]   q
);

  generate
    if (ROUND != 0) begin : g_round
      logic [PIX_W:0] sum;
      always_comb begin
        sum = {1'b0, pixel} + (PIX_W+1)'(8);
        // Carry into bit PIX_W means the rounded value exceeds the 4-bit range.
        q   = sum[PIX_W] ? '1 : sum[PIX_W-1 -: Q_W];
      end
    end else begin : g_trunc
      always_comb q = pixel[PIX_W-1 -: Q_W];
    end
  endgenerate

endmodule

// File: rtl/mnist_image_loader.sv
// Loads one quantized 784-pixel frame into the engine input RAM, starts the engine and returns its class.
module mnist_image_loader
  import mlp_pkg::*;
#(
  parameter int NUM_PIXELS     = mlp_pkg::NUM_PIXELS,
  parameter int ADDR_W         = 10,
  parameter int ROUND          = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                clk,
  input logic                reset,
  mnist_image_loader_if.master bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  loader_state_t     state;
  logic [ADDR_W-1:0] pixel_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [Q_W-1:0]    q;
  logic              accept;
  logic              at_last_pixel;

  logic              ram_wen_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [Q_W-1:0]    ram_wdata_r;
  logic              mlp_start_r;
  logic              mlp_clear_r;
  logic              result_valid_r;
  logic [3:0]        result_class_r;
  logic              frame_error_r;

  pixel_quantizer #(.ROUND(ROUND)) u_quant (
    .pixel (bus.s_data),
    .q     (q)
  );

  assign bus.s_ready   = (state == LOAD) || (state == DRAIN);
  assign accept        = bus.s_valid & bus.s_ready;
  assign at_last_pixel = (pixel_cnt == ADDR_W'(NUM_PIXELS - 1));

  assign bus.ram_wen      = ram_wen_r;
  assign bus.ram_addr     = ram_addr_r;
  assign bus.ram_wdata    = ram_wdata_r;
  assign bus.mlp_start    = mlp_start_r;
  assign bus.mlp_clear    = mlp_clear_r;
  assign bus.result_valid = result_valid_r;
  assign bus.result_class = result_class_r;
  assign bus.frame_error  = frame_error_r;
  assign bus.state_dbg    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LOAD;
      pixel_cnt      <= '0;
      tmo_cnt        <= '0;
      ram_wen_r      <= 1'b0;
      ram_addr_r     <= '0;
      ram_wdata_r    <= '0;
      mlp_start_r    <= 1'b0;
      mlp_clear_r    <= 1'b0;
      result_valid_r <= 1'b0;
      result_class_r <= '0;
      frame_error_r  <= 1'b0;
    end else begin
      ram_wen_r     <= 1'b0;
      mlp_start_r   <= 1'b0;
      mlp_clear_r   <= 1'b0;
      frame_error_r <= 1'b0;

      case (state)
        LOAD: begin
          if (accept) begin
            ram_wen_r   <= 1'b1;
            ram_addr_r  <= pixel_cnt;
            ram_wdata_r <= q;
            if (at_last_pixel) begin
              pixel_cnt <= '0;
              if (bus.s_last) begin
                state <= START;
              end else begin
                // Frame overran without s_last: drop everything up to the next s_last.
                frame_error_r <= 1'b1;
                state         <= DRAIN;
              end
            end else if (bus.s_last) begin
              frame_error_r <= 1'b1;
              pixel_cnt     <= '0;
            end else begin
              pixel_cnt <= pixel_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (accept && bus.s_last) state <= LOAD;
        end

        START: begin
          // The final RAM write is visible this cycle, so the start pulse lands one cycle later.
          mlp_start_r <= 1'b1;
          tmo_cnt     <= '0;
          state       <= WAIT;
        end

        WAIT: begin
          if (bus.mlp_done && !mlp_start_r) begin
            result_class_r <= bus.mlp_class;
            result_valid_r <= 1'b1;
            mlp_clear_r    <= 1'b1;
            state          <= RESULT;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            frame_error_r <= 1'b1;
            mlp_clear_r   <= 1'b1;
            tmo_cnt       <= '0;
            state         <= LOAD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RESULT: begin
          if (bus.result_ready) begin
            result_valid_r <= 1'b0;
            pixel_cnt      <= '0;
            tmo_cnt        <= '0;
            state          <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/mnist_image_loader.md
Name: mnist_image_loader

Overview:
- Upstream stage of the int4 MLP inference engine. Accepts an 8-bit pixel stream (784 pixels, row-major, one frame per inference) over a valid/ready handshake and quantizes each pixel to unsigned 4 bits.
- Writes quantized pixels into the engine's input-RAM write port, then pulses the engine start and waits for done.
- Returns the predicted class on a valid/ready result interface, then clears the engine for the next frame.

Parameters:
- NUM_PIXELS, 784, pixels per frame; input-RAM depth.
- ADDR_W, 10, input-RAM address width; must satisfy 2^ADDR_W >= NUM_PIXELS.
- ROUND, 1, quantizer mode: 1 = round-half-up with saturation, 0 = truncate (pixel >> 4).
- TIMEOUT_CYCLES, 100000, maximum cycles to wait for mlp_done before flagging an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_valid  in  1  pixel valid
- s_ready  out  1  loader can accept a pixel
- s_data  in  8  unsigned pixel, 0..255
- s_last  in  1  marks the final pixel of a frame
- ram_wen  out  1  input-RAM write enable
- ram_addr  out  ADDR_W  input-RAM write address
- ram_wdata  out  4  quantized pixel
- mlp_start  out  1  one-cycle start pulse to the engine
- mlp_done  in  1  engine done, level (held high until cleared)
- mlp_class  in  4  engine predicted_class, valid while mlp_done = 1
- mlp_clear  out  1  one-cycle synchronous clear to the engine
- result_valid  out  1  result available
- result_class  out  4  predicted digit
- result_ready  in  1  consumer accepts the result
- frame_error  out  1  one-cycle pulse on framing error or timeout

Behaviour:
- Reset values: all outputs 0; state LOAD; pixel_cnt 0; timeout counter 0. s_ready is combinational and equals 1 in LOAD only.
- Handshake: a pixel is accepted on a rising clk edge where s_valid & s_ready. s_data and s_last are ignored otherwise.
- Quantizer:
  - ROUND = 1: q = min((s_data + 8) >> 4, 15), computed at 9-bit width.
  - ROUND = 0: q = s_data[7:4].
  - Examples: 0 -> 0, 7 -> 0, 8 -> 1, 247 -> 15, 255 -> 15.
- Write path: registered. The cycle after an accepted pixel: ram_wen = 1, ram_addr = pixel_cnt at acceptance, ram_wdata = q. Back-to-back acceptance gives one write per cycle. ram_wen = 0 otherwise.
- States:
  - LOAD
    - On acceptance, pixel_cnt increments.
    - Normal frame end: acceptance with pixel_cnt == NUM_PIXELS-1 and s_last = 1. The write occurs; go to START.
    - Framing error, early last: s_last = 1 with pixel_cnt < NUM_PIXELS-1. Pulse frame_error, pixel_cnt <- 0, stay in LOAD. The partial write still occurs and is harmless.
    - Framing error, missing last: pixel NUM_PIXELS-1 accepted with s_last = 0. Pulse frame_error, pixel_cnt <- 0, discard input until s_last is seen (sub-state DRAIN, s_ready = 1, no writes), then resume LOAD.
  - START: entered the cycle the final write is registered. mlp_start = 1 for exactly this cycle, which is one cycle after the last ram_wen pulse, so the RAM is fully written. Go to WAIT.
  - WAIT
    - Timeout counter increments each cycle.
    - mlp_done = 1: capture result_class <- mlp_class, result_valid <- 1, pulse mlp_clear, go to RESULT.
    - Counter reaches TIMEOUT_CYCLES-1: pulse frame_error and mlp_clear, result_valid stays 0, go to LOAD.
    - mlp_done is ignored in the START cycle.
  - RESULT
    - result_valid and result_class are held stable until result_ready.
    - On result_valid & result_ready: result_valid <- 0, pixel_cnt <- 0, timeout counter <- 0, go to LOAD.
    - result_ready while result_valid = 0 has no effect.
- Simultaneous events: in WAIT, mlp_done and timeout in the same cycle resolve as done (result wins).
- Reset mid-frame or mid-inference: asynchronous return to LOAD with pixel_cnt 0. Any pending result is lost. mlp_clear is not issued; the engine is expected to share reset.
- Exactly one mlp_start pulse per good frame. frame_error never coincides with mlp_start.

Decomposition:
- Shared package mlp_pkg holds:
  - NUM_PIXELS = 784 and NUM_CLASSES = 10.
  - PIX_W = 8 and Q_W = 4.
  - The loader state encoding (LOAD, DRAIN, START, WAIT, RESULT) as localparams.
- Sub-module pixel_quantizer: combinational, 8 -> 4 bits, carries the ROUND parameter; reused by future camera/UART front ends.
- Counters and FSM stay in mnist_image_loader.

Test Plan:
- Good frame, ROUND = 1, pixels i mod 256, s_valid continuous, s_last on pixel 783:
  - 784 ram_wen pulses at addresses 0..783, with wdata[8] = 1 and wdata[255] = 15.
  - mlp_start exactly one cycle after the write to address 783.
  - s_ready = 0 from START onward.
- Engine model raises mlp_done with mlp_class = 7 after 50 cycles, result_ready held low for 20 cycles:
  - result_class = 7 and result_valid held for the whole stall.
  - mlp_clear pulses once.
  - Returns to LOAD the cycle after result_ready.
- s_last asserted on pixel 100:
  - frame_error pulses one cycle and no mlp_start.
  - The next clean 784-pixel frame writes from address 0 and starts normally.
- 800 pixels with s_last only on the 800th:
  - frame_error at pixel 783 and no writes for pixels 784..799.
  - The next frame is accepted.
- mlp_done never asserted, TIMEOUT_CYCLES = 1000:
  - frame_error and mlp_clear pulse 1000 cycles after mlp_start.
  - result_valid stays 0 and the loader returns to LOAD.
- Randomized s_valid gaps, plus reset asserted mid-frame at pixel 400:
  - All outputs are 0 immediately.
  - The next full frame produces a correct write sequence and a single start.
